scc_boot_ctrl: RTL and testbench

// - Upstream boot/run sequencer for scc_f25_top: streams a program image into instruction memory,

---
 rtl/scc_pkg.sv | 19 +
 rtl/scc_sat_counter.sv | 35 +++
 rtl/scc_boot_ctrl.sv | 156 +++++++++++++++
 tb/tb_scc_boot_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared state and status encodings for the SCC boot controller
package scc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_HALTED  = 3'd4,
    S_FAULT   = 3'd5,
    S_TIMEOUT = 3'd6
  } scc_state_t;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

endpackage

// File: rtl/scc_sat_counter.sv
// rtl/scc_sat_counter.sv - clearable up-counter that sticks at all-ones
module scc_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Clear wins over increment; increment stops once the counter is saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/scc_boot_ctrl.sv
// rtl/scc_boot_ctrl.sv - loads a program image, releases the core from reset and supervises the run
module scc_boot_ctrl
  import scc_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RST_HOLD   = 3,
  parameter int WDOG_LIMIT = 3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              core_clk_en,
  input  logic              halt_f,
  input  logic [1:0]        err_bits,
  output logic              busy,
  output logic [1:0]        status,
  output logic [1:0]        err_latched,
  output logic [31:0]       run_cycles
);

  localparam int          HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
  localparam bit          WDOG_EN   = (WDOG_LIMIT != 0);
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_LIMIT - 1);

  scc_state_t        state_q;
  logic              s_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [DATA_W-1:0] imem_wdata_q;
  logic [ADDR_W-1:0] wptr_q;
  logic              core_rst_q;
  logic              core_clk_en_q;
  logic              busy_q;
  logic [1:0]        status_q;
  logic [1:0]        err_latched_q;
  logic [HOLD_W-1:0] hold_q;

  logic start_ok;
  logic in_run;

  // A new load may begin from idle or from any terminal state.
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_HALTED) ||
                              (state_q == S_FAULT) || (state_q == S_TIMEOUT));
  assign in_run   = (state_q == S_RUN);

  scc_sat_counter #(
    .WIDTH (32)
  ) u_run_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (start_ok),
    .inc_i   (in_run),
    .count_o (run_cycles)
  );

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      s_ready_q     <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      wptr_q        <= '0;
      core_rst_q    <= 1'b1;
      core_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
      status_q      <= ST_RUN;
      err_latched_q <= 2'b00;
      hold_q        <= '0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALTED, S_FAULT, S_TIMEOUT: begin
          if (start) begin
            state_q       <= S_LOAD;
            s_ready_q     <= 1'b1;
            core_rst_q    <= 1'b1;
            core_clk_en_q <= 1'b0;
            busy_q        <= 1'b1;
            status_q      <= ST_RUN;
            err_latched_q <= 2'b00;
            wptr_q        <= '0;
            imem_addr_q   <= '0;
          end
        end
        S_LOAD: begin
          if (s_valid && s_ready_q) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= wptr_q;
            imem_wdata_q <= s_data;
            wptr_q       <= wptr_q + ADDR_W'(1);
            if (s_last) begin
              state_q   <= S_RELEASE;
              s_ready_q <= 1'b0;
              hold_q    <= HOLD_INIT;
            end
          end
        end
        S_RELEASE: begin
          // One cycle for the last write to land, then RST_HOLD cycles of reset.
          if (hold_q == '0) begin
            state_q       <= S_RUN;
            core_rst_q    <= 1'b0;
            core_clk_en_q <= 1'b1;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (err_bits != 2'b00) begin
            state_q       <= S_FAULT;
            err_latched_q <= err_bits;
            status_q      <= ST_FAULT;
            core_clk_en_q <= 1'b0;
            busy_q        <= 1'b0;
          end else if (halt_f) begin
            state_q       <= S_HALTED;
            status_q      <= ST_HALT;
            core_clk_en_q <= 1'b0;
            busy_q        <= 1'b0;
          end else if (WDOG_EN && (run_cycles == WDOG_LAST)) begin
            state_q       <= S_TIMEOUT;
            status_q      <= ST_TMO;
            core_clk_en_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign core_rst    = core_rst_q;
  assign core_clk_en = core_clk_en_q;
  assign busy        = busy_q;
  assign status      = status_q;
  assign err_latched = err_latched_q;

endmodule

// File: tb/tb_scc_boot_ctrl.sv
// tb/tb_scc_boot_ctrl.sv - self-checking bench for scc_boot_ctrl against a phase-level model
module tb_scc_boot_ctrl;

  localparam int RST_HOLD   = 3;
  localparam int WDOG_LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        core_clk_en;
  logic        halt_f = 1'b0;
  logic [1:0]  err_bits = 2'b00;
  logic        busy;
  logic [1:0]  status;
  logic [1:0]  err_latched;
  logic [31:0] run_cycles;

  int checks = 0;
  int errors = 0;

  scc_boot_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .RST_HOLD   (RST_HOLD),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_rst    (core_rst),
    .core_clk_en (core_clk_en),
    .halt_f      (halt_f),
    .err_bits    (err_bits),
    .busy        (busy),
    .status      (status),
    .err_latched (err_latched),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: outputs follow from which phase the sequencer is in.
  localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_HALT = 4, P_FAULT = 5, P_TMO = 6;
  int          ph;
  int          m_rel_left;
  int          m_ptr;
  bit          m_we;
  bit   [15:0] m_addr;
  bit   [31:0] m_wdata;
  bit   [31:0] m_cyc;
  bit   [1:0]  m_err;

  function automatic void model_reset();
    ph = P_IDLE; m_rel_left = 0; m_ptr = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_cyc = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    m_we = 0;
    case (ph)
      P_IDLE, P_HALT, P_FAULT, P_TMO: begin
        if (start) begin
          ph = P_LOAD; m_ptr = 0; m_addr = 0; m_cyc = 0; m_err = 0;
        end
      end
      P_LOAD: begin
        if (s_valid) begin
          m_we = 1; m_addr = 16'(m_ptr); m_wdata = s_data;
          m_ptr = (m_ptr + 1) % 65536;
          if (s_last) begin
            ph = P_REL; m_rel_left = RST_HOLD + 1;
          end
        end
      end
      P_REL: begin
        m_rel_left--;
        if (m_rel_left == 0) ph = P_RUN;
      end
      P_RUN: begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (err_bits != 2'b00) begin
          ph = P_FAULT; m_err = err_bits;
        end else if (halt_f) begin
          ph = P_HALT;
        end else if (WDOG_LIMIT != 0 && m_cyc == 32'(WDOG_LIMIT)) begin
          ph = P_TMO;
        end
      end
      default: ph = P_IDLE;
    endcase
  endfunction

  // Compare every cycle on the falling edge, then advance the model with the inputs
  // the next rising edge will sample.
  always @(negedge clk) begin
    logic [1:0] exp_status;
    if (!rst) model_reset();
    exp_status = (ph == P_HALT) ? 2'b01 : (ph == P_FAULT) ? 2'b10 : (ph == P_TMO) ? 2'b11 : 2'b00;
    chk("m_s_ready", 32'(s_ready), 32'(ph == P_LOAD));
    chk("m_core_rst", 32'(core_rst), 32'(ph == P_IDLE || ph == P_LOAD || ph == P_REL));
    chk("m_core_clk_en", 32'(core_clk_en), 32'(ph == P_RUN));
    chk("m_busy", 32'(busy), 32'(ph == P_LOAD || ph == P_REL || ph == P_RUN));
    chk("m_status", 32'(status), 32'(exp_status));
    chk("m_err_latched", 32'(err_latched), 32'(m_err));
    chk("m_run_cycles", run_cycles, m_cyc);
    chk("m_imem_we", 32'(imem_we), 32'(m_we));
    chk("m_imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("m_imem_wdata", imem_wdata, m_wdata);
    if (rst) model_step();
  end

  // Log of memory writes for literal image checks.
  logic [47:0] wr_log[$];
  always @(negedge clk) begin
    if (rst && imem_we) wr_log.push_back({imem_addr, imem_wdata});
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Call at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("load_ready_wait", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Called right after the s_last accept; returns on the negedge where core_clk_en is seen.
  task automatic check_release(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (core_clk_en) break;
    end
    chk(name, 32'(n), 32'(1 + RST_HOLD));
  endtask

  logic [31:0] img_a[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] img_b[3] = '{32'hA1, 32'hA2, 32'hA3};

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_clk_en", 32'(core_clk_en), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Image A: four back-to-back words, halt at run cycle 10.
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(img_a[i], i == 3);
    check_release("latency_a");
    chk("a_nwrites", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      chk("a_addr", 32'(wr_log[i][47:32]), 32'(i));
      chk("a_data", wr_log[i][31:0], img_a[i]);
    end
    repeat (10) @(posedge clk);
    #1 halt_f = 1'b1;
    @(posedge clk); #1 halt_f = 1'b0;
    @(negedge clk);
    chk("halt_status", 32'(status), 32'h1);
    chk("halt_clk_en", 32'(core_clk_en), 32'h0);
    chk("halt_run_cycles", run_cycles, 32'd11);
    chk("halt_core_rst", 32'(core_rst), 32'h0);

    // Image B: gapped stream, start/s_valid ignored in RUN, then fault beats halt.
    wr_log.delete();
    pulse_start();
    @(negedge clk);
    chk("restart_addr", 32'(imem_addr), 32'h0);
    chk("restart_run_cycles", run_cycles, 32'h0);
    @(posedge clk); #1;
    send_word(img_b[0], 1'b0);
    idle_cycle();
    send_word(img_b[1], 1'b0);
    idle_cycle();
    idle_cycle();
    send_word(img_b[2], 1'b1);
    check_release("latency_b");
    @(posedge clk); #1 start = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD;
    @(posedge clk); #1 start = 1'b0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 err_bits = 2'b10; halt_f = 1'b1;
    @(posedge clk); #1 err_bits = 2'b00; halt_f = 1'b0;
    @(negedge clk);
    chk("fault_status", 32'(status), 32'h2);
    chk("fault_err", 32'(err_latched), 32'h2);
    chk("fault_clk_en", 32'(core_clk_en), 32'h0);
    chk("b_nwrites", 32'(wr_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      chk("b_addr", 32'(wr_log[i][47:32]), 32'(i));
      chk("b_data", wr_log[i][31:0], img_b[i]);
    end

    // Image C: never halts, watchdog fires after WDOG_LIMIT run cycles.
    pulse_start();
    @(negedge clk);
    chk("clr_err", 32'(err_latched), 32'h0);
    chk("clr_status", 32'(status), 32'h0);
    @(posedge clk); #1;
    send_word(32'h5, 1'b0);
    send_word(32'h6, 1'b1);
    check_release("latency_c");
    n = 0;
    while (status != 2'b11 && n < WDOG_LIMIT + 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_status", 32'(status), 32'h3);
    chk("tmo_run_cycles", run_cycles, 32'd3000);
    chk("tmo_busy", 32'(busy), 32'h0);

    // Restart from timeout, then async reset in the middle of a run.
    pulse_start();
    @(negedge clk);
    chk("tmo_restart_addr", 32'(imem_addr), 32'h0);
    chk("tmo_restart_err", 32'(err_latched), 32'h0);
    chk("tmo_restart_ready", 32'(s_ready), 32'h1);
    @(posedge clk); #1;
    send_word(32'h77, 1'b0);
    send_word(32'h88, 1'b1);
    check_release("latency_d");
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_core_rst", 32'(core_rst), 32'h1);
    chk("arst_clk_en", 32'(core_clk_en), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_run_cycles", run_cycles, 32'h0);
    chk("arst_addr", 32'(imem_addr), 32'h0);
    chk("arst_wdata", imem_wdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_rst", 32'(core_rst), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
